// File: rtl/mem_access.sv
// Memory stage between execute and complete: non-memory ops pass through, loads and
// stores run a req/gnt/rvalid transaction, loads are lane-aligned and sign/zero-extended.
module mem_access #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_NPC,
    input  logic            in_take_branch,
    input  logic [4:0]      in_dest_reg_idx,
    input  logic            in_rd_mem,
    input  logic            in_wr_mem,
    input  logic [1:0]      in_mem_size,
    input  logic            in_rd_unsigned,
    input  logic [XLEN-1:0] in_rs2_value,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [4:0]      out_dest_reg_idx,
    output logic            out_take_branch,
    output logic [XLEN-1:0] out_NPC,
    output logic [XLEN-1:0] out_result,
    output logic            out_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LD} state_t;

    state_t          state_q;
    logic [31:0]     cnt_q;
    logic [XLEN-1:0] res_q, npc_q;
    logic [4:0]      dest_q;
    logic            tb_q, uns_q;
    logic [1:0]      size_q, lane_q;
    logic            mem_req_q, mem_we_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
    logic [3:0]      mem_be_q;
    logic            out_valid_q, out_tb_q, out_fault_q;
    logic [4:0]      out_dest_q;
    logic [XLEN-1:0] out_npc_q, out_result_q;

    logic            is_mem, misaligned;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d, lane_word, load_d;

    always_comb begin
        is_mem     = in_rd_mem | in_wr_mem;
        misaligned = ((in_mem_size == 2'b01) && in_alu_result[0]) ||
                     (in_mem_size[1] && (in_alu_result[1:0] != 2'b00));
        case (in_mem_size)
            2'b00:   be_d = 4'b0001 << in_alu_result[1:0];
            2'b01:   be_d = 4'b0011 << in_alu_result[1:0];
            default: be_d = 4'b1111;
        endcase
        wdata_d   = in_rs2_value << {in_alu_result[1:0], 3'b000};
        // Shift the addressed lane down to bit 0, then extend from its MSB.
        lane_word = mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   load_d = {{(XLEN-8){~uns_q & lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_d = {{(XLEN-16){~uns_q & lane_word[15]}}, lane_word[15:0]};
            default: load_d = lane_word;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            res_q        <= '0;
            npc_q        <= '0;
            dest_q       <= '0;
            tb_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= '0;
            lane_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            out_valid_q  <= 1'b0;
            out_tb_q     <= 1'b0;
            out_fault_q  <= 1'b0;
            out_dest_q   <= '0;
            out_npc_q    <= '0;
            out_result_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem || misaligned) begin
                            out_valid_q  <= 1'b1;
                            out_fault_q  <= is_mem;
                            out_dest_q   <= is_mem ? 5'd0 : in_dest_reg_idx;
                            out_tb_q     <= in_take_branch;
                            out_npc_q    <= in_NPC;
                            out_result_q <= in_alu_result;
                        end else begin
                            res_q       <= in_alu_result;
                            npc_q       <= in_NPC;
                            dest_q      <= in_dest_reg_idx;
                            tb_q        <= in_take_branch;
                            uns_q       <= in_rd_unsigned;
                            size_q      <= in_mem_size;
                            lane_q      <= in_alu_result[1:0];
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= in_wr_mem;
                            mem_addr_q  <= {in_alu_result[XLEN-1:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            out_valid_q  <= 1'b1;
                            out_fault_q  <= 1'b0;
                            out_dest_q   <= dest_q;
                            out_tb_q     <= tb_q;
                            out_npc_q    <= npc_q;
                            out_result_q <= res_q;
                            state_q      <= IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= WAIT_LD;
                        end
                    end
                end
                WAIT_LD: begin
                    if (mem_rvalid) begin
                        out_valid_q  <= 1'b1;
                        out_fault_q  <= 1'b0;
                        out_dest_q   <= dest_q;
                        out_tb_q     <= tb_q;
                        out_npc_q    <= npc_q;
                        out_result_q <= load_d;
                        state_q      <= IDLE;
                    end else if ((MEM_TIMEOUT != 0) && (cnt_q == MEM_TIMEOUT - 1)) begin
                        out_valid_q  <= 1'b1;
                        out_fault_q  <= 1'b1;
                        out_dest_q   <= '0;
                        out_tb_q     <= tb_q;
                        out_npc_q    <= npc_q;
                        out_result_q <= res_q;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_be           = mem_be_q;
    assign mem_wdata        = mem_wdata_q;
    assign out_valid        = out_valid_q;
    assign out_dest_reg_idx = out_dest_q;
    assign out_take_branch  = out_tb_q;
    assign out_NPC          = out_npc_q;
    assign out_result       = out_result_q;
    assign out_fault        = out_fault_q;

endmodule
